// File: rtl/lru_req_driver.sv
// lru_req_driver: issues a programmed address sequence to the cache front end and grades each response
module lru_req_driver #(
    parameter int          TAGS_WIDTH = 48,
    parameter int          DATA_WIDTH = 64,
    parameter int          HIT_LAT    = 2,
    parameter int          TIMEOUT    = 1024,
    parameter logic [63:0] DATA_SEED  = 64'h0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [TAGS_WIDTH-1:0] cfg_base,
    input  logic [TAGS_WIDTH-1:0] cfg_stride,
    input  logic [TAGS_WIDTH-1:0] cfg_wrap_mask,
    input  logic [31:0]           cfg_count,
    input  logic                  cfg_check_en,
    output logic [TAGS_WIDTH-1:0] addr_tdata,
    output logic                  addr_tvalid,
    input  logic                  addr_tready,
    input  logic [DATA_WIDTH-1:0] data_tdata,
    input  logic                  data_tvalid,
    output logic                  data_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [31:0]           req_cnt,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [31:0]           err_cnt,
    output logic [15:0]           lat_max,
    output logic [TAGS_WIDTH-1:0] err_addr
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;
    localparam logic [15:0] HL = 16'(HIT_LAT);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(DATA_SEED);
    state_t state, state_n;
    logic [TAGS_WIDTH-1:0] base, stride, mask, offset;
    logic [31:0] count, req_n;
    logic [15:0] lat;
    logic check_en, launch, acc, resp, tmo, hit, mism;
    always_comb begin
        addr_tdata  = base + offset;
        addr_tvalid = state == SEND;
        data_tready = state == WAIT;
        busy        = state != IDLE;
        done        = state == FIN;
        launch      = state == IDLE && start;
        acc         = addr_tvalid && addr_tready;
        resp        = data_tvalid && data_tready;
        tmo         = data_tready && !data_tvalid && lat >= TO;
        hit         = lat <= HL;
        mism        = check_en && data_tdata != (DATA_WIDTH'(addr_tdata) ^ SEED);
        req_n       = req_cnt + 32'(req_cnt != '1);
        state_n     = launch ? (cfg_count == '0 ? FIN : SEND) :
                      acc    ? WAIT :
                      resp   ? (req_n == count ? FIN : SEND) :
                      tmo    ? FIN :
                      done   ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base        <= '0;
            stride      <= '0;
            mask        <= '0;
            count       <= '0;
            check_en    <= 1'b0;
            offset      <= '0;
            lat         <= '0;
            timeout_err <= 1'b0;
            req_cnt     <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            err_cnt     <= '0;
            lat_max     <= '0;
            err_addr    <= '0;
        end else begin
            if (launch) begin
                base        <= cfg_base;
                stride      <= cfg_stride;
                mask        <= cfg_wrap_mask;
                count       <= cfg_count;
                check_en    <= cfg_check_en;
                offset      <= '0;
                timeout_err <= 1'b0;
                req_cnt     <= '0;
                hit_cnt     <= '0;
                miss_cnt    <= '0;
                err_cnt     <= '0;
                lat_max     <= '0;
                err_addr    <= '0;
            end
            if (acc) lat <= 16'd1;
            else if (data_tready) lat <= lat + 16'(lat != '1);
            if (tmo) timeout_err <= 1'b1;
            // a timed-out request leaves every statistic untouched
            if (resp) begin
                req_cnt <= req_n;
                if (hit) hit_cnt <= hit_cnt + 32'(hit_cnt != '1);
                else miss_cnt <= miss_cnt + 32'(miss_cnt != '1);
                if (lat > lat_max) lat_max <= lat;
                if (mism) err_cnt <= err_cnt + 32'(err_cnt != '1);
                if (mism && err_cnt == '0) err_addr <= addr_tdata;
                offset <= (offset + stride) & mask;
            end
        end
    end
endmodule

// File: tb/tb_lru_req_driver.sv
// tb_lru_req_driver: directed scoreboard bench with an 8-way LRU responder model
module tb_lru_req_driver;
    localparam int TW = 48;
    localparam int DW = 64;
    localparam int TMO = 1024;
    localparam logic [63:0] SEED = 64'h0123_4567_89ab_cdef;
    logic clk = 0, rstn = 0, start = 0, cfg_check_en = 0, addr_tready = 1;
    logic [TW-1:0] cfg_base = '0, cfg_stride = '0, cfg_wrap_mask = '0;
    logic [31:0] cfg_count = '0;
    logic [TW-1:0] addr_tdata, err_addr;
    logic addr_tvalid, data_tvalid, data_tready, busy, done, timeout_err;
    logic [DW-1:0] data_tdata;
    logic [31:0] req_cnt, hit_cnt, miss_cnt, err_cnt;
    logic [15:0] lat_max;
    int total = 0, bad = 0, n_acc = 0, hit_l = 1, miss_l = 5, dones, cyc;
    bit silent = 0, saw_valid;
    logic [TW-1:0] c_a = '1, c_b = '1;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] lru[$];

    lru_req_driver #(.TAGS_WIDTH(TW), .DATA_WIDTH(DW), .HIT_LAT(2), .TIMEOUT(TMO), .DATA_SEED(SEED)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .cfg_wrap_mask(cfg_wrap_mask), .cfg_count(cfg_count), .cfg_check_en(cfg_check_en),
        .addr_tdata(addr_tdata), .addr_tvalid(addr_tvalid), .addr_tready(addr_tready),
        .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
        .busy(busy), .done(done), .timeout_err(timeout_err), .req_cnt(req_cnt), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .err_cnt(err_cnt), .lat_max(lat_max), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // responder: hits answer after hit_l cycles, misses after miss_l cycles
    initial begin
        logic hs, h;
        logic [TW-1:0] a, ea;
        int idx[$];
        data_tvalid = 0;
        data_tdata = '0;
        forever begin
            @(negedge clk);
            #3;
            hs = addr_tvalid && addr_tready;
            a = addr_tdata;
            @(posedge clk);
            if (hs) begin
                n_acc++;
                ea = 'x;
                if (exp_q.size() > 0) ea = exp_q.pop_front();
                check("req_addr", a, ea);
                if (!silent) begin
                    idx = lru.find_first_index(x) with (x == a);
                    h = idx.size() > 0;
                    if (h) lru.delete(idx[0]);
                    lru.push_back(a);
                    if (lru.size() > 8) void'(lru.pop_front());
                    repeat ((h ? hit_l : miss_l) - 1) @(posedge clk);
                    #1;
                    data_tdata = {16'h0, a} ^ SEED ^ {63'h0, (a == c_a || a == c_b)};
                    data_tvalid = 1;
                    @(posedge clk);
                    #1 data_tvalid = 0;
                end
            end
        end
    end

    task automatic run(input logic [TW-1:0] b, input logic [TW-1:0] s, input logic [TW-1:0] m,
                       input int cnt, input bit chk, input int hold, input int limit);
        logic [TW-1:0] off;
        int acc0;
        off = '0;
        cfg_base = b;
        cfg_stride = s;
        cfg_wrap_mask = m;
        cfg_count = cnt;
        cfg_check_en = chk;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(b + off);
            off = (off + s) & m;
        end
        if (hold > 0) addr_tready = 0;
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        acc0 = n_acc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {addr_tvalid, addr_tdata, 32'(n_acc)}, {1'b1, b, 32'(acc0)});
        end
        #1 addr_tready = 1;
        if (hold > 0) begin
            @(posedge clk);
            #1 check("accept_cycle", n_acc, acc0 + 1);
        end
        dones = 0;
        cyc = 0;
        saw_valid = 0;
        while (dones == 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            saw_valid |= addr_tvalid;
            if (done) dones++;
        end
        @(negedge clk);
        check("busy_after_done", busy, 0);
        if (done) dones++;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("done_pulses", dones, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check("reset_state", {addr_tdata, addr_tvalid, data_tready, busy, done, timeout_err,
                 req_cnt, hit_cnt, miss_cnt, err_cnt, lat_max, err_addr}, 0);
        rstn = 1;
        // mid-run reset
        run_start_only();
        repeat (12) @(posedge clk);
        #1 rstn = 0;
        repeat (3) begin
            @(posedge clk);
            #1 check("midrun_reset", {addr_tdata, addr_tvalid, data_tready, busy, done, timeout_err,
                     req_cnt, hit_cnt, miss_cnt, err_cnt, lat_max, err_addr}, 0);
        end
        rstn = 1;
        exp_q.delete();
        repeat (6) begin
            @(negedge clk);
            check("post_reset_quiet", {addr_tvalid, done, busy}, 0);
        end
        // sequential addresses, cold cache
        lru.delete();
        run('0, 48'd1, '1, 8, 1, 0, 200);
        check("seq_stats", {req_cnt, hit_cnt, miss_cnt, err_cnt, lat_max, timeout_err},
              {32'd8, 32'd0, 32'd8, 32'd0, 16'd5, 1'b0});
        check("seq_drained", exp_q.size(), 0);
        // wrap mask 1 on 8-way cache
        lru.delete();
        run('0, 48'd1, 48'd1, 6, 1, 0, 200);
        check("wrap_stats", {req_cnt, hit_cnt, miss_cnt, lat_max}, {32'd6, 32'd4, 32'd2, 16'd5});
        check("wrap_drained", exp_q.size(), 0);
        // latency exactly at and just above the hit threshold
        hit_l = 2;
        miss_l = 3;
        lru.delete();
        run('0, 48'd1, 48'd1, 6, 1, 0, 200);
        check("hitlat_edge", {req_cnt, hit_cnt, miss_cnt, lat_max}, {32'd6, 32'd4, 32'd2, 16'd3});
        hit_l = 1;
        miss_l = 5;
        // backpressure on the address channel
        lru.delete();
        run(48'h100, 48'h10, '1, 2, 1, 5, 100);
        check("bp_stats", {req_cnt, miss_cnt, err_cnt}, {32'd2, 32'd2, 32'd0});
        check("bp_drained", exp_q.size(), 0);
        // corrupted data, first-error capture
        lru.delete();
        c_a = 48'd3;
        c_b = 48'd5;
        run('0, 48'd1, '1, 8, 1, 0, 200);
        check("err_stats", {req_cnt, err_cnt, err_addr}, {32'd8, 32'd2, 48'd3});
        run('0, 48'd1, '1, 8, 0, 0, 200);
        check("nochk_stats", {req_cnt, hit_cnt, err_cnt, err_addr, lat_max},
              {32'd8, 32'd8, 32'd0, 48'd0, 16'd1});
        c_a = '1;
        c_b = '1;
        // silent responder, then an empty run
        silent = 1;
        run(48'h40, 48'd4, '1, 2, 1, 0, 1200);
        check("tmo_window", (cyc >= TMO - 4 && cyc <= TMO + 6), 1);
        check("tmo_stats", {timeout_err, req_cnt, hit_cnt, miss_cnt, lat_max}, {1'b1, 96'd0, 16'd0});
        check("tmo_left", exp_q.size(), 1);
        exp_q.delete();
        silent = 0;
        run('0, 48'd1, '1, 0, 1, 0, 10);
        check("zero_run", {saw_valid, timeout_err, req_cnt, 32'(cyc)}, {1'b0, 1'b0, 32'd0, 32'd1});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic run_start_only();
        lru.delete();
        cfg_base = '0;
        cfg_stride = 48'd1;
        cfg_wrap_mask = '1;
        cfg_count = 8;
        cfg_check_en = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(48'(i));
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
